// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: AXI4 bus bundle (AW/W/B/AR/R) between axi_burst_master and a slave
interface axi_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast, wvalid, wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid, bready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid, arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast, rvalid, rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 INCR burst master; one command -> one burst.
// Define AXIM_RESP_CHECK_EN to report bresp / worst rresp (and short read bursts) on done_status_o.
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  output logic                  done_valid_o,
  output logic [1:0]            done_status_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [STRB_WIDTH-1:0] wr_strb_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  axi_burst_master_if.master    m_axi
);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0] len_q, cnt_q, cnt_d;
  logic done_q, done_d, w_hs, r_hs;
  assign cmd_ready_o = state_q == IDLE;
  assign w_hs = m_axi.wvalid && m_axi.wready;
  assign r_hs = m_axi.rvalid && m_axi.rready;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cmd_valid_i ? (cmd_write_i ? AW : AR) : IDLE;
      AW:      state_d = m_axi.awready ? W : AW;
      W:       state_d = (w_hs && m_axi.wlast) ? B : W;
      B:       state_d = m_axi.bvalid ? IDLE : B;
      AR:      state_d = m_axi.arready ? R : AR;
      R:       state_d = (r_hs && m_axi.rlast) ? IDLE : R;
      default: state_d = IDLE;
    endcase
    cnt_d = ((state_q == AW && m_axi.awready) || (state_q == AR && m_axi.arready)) ? 8'd0 :
            (w_hs || r_hs) ? cnt_q + 8'd1 : cnt_q;
    done_d = (state_q == B && m_axi.bvalid) || (r_hs && m_axi.rlast);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (cmd_valid_i && cmd_ready_o) begin
        addr_q <= cmd_addr_i;
        len_q  <= cmd_len_i;
      end
    end
  end
  assign done_valid_o = done_q;
  assign m_axi.awid    = ID_WIDTH'(AXI_ID);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = state_q == AW;
  assign m_axi.arid    = ID_WIDTH'(AXI_ID);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = state_q == AR;
  assign m_axi.wdata   = wr_data_i;
  assign m_axi.wstrb   = wr_strb_i;
  assign m_axi.wvalid  = state_q == W && wr_valid_i;
  assign m_axi.wlast   = cnt_q == len_q;
  assign wr_ready_o    = state_q == W && m_axi.wready;
  assign m_axi.bready  = state_q == B;
  assign m_axi.rready  = state_q == R && rd_ready_i;
  assign rd_valid_o    = state_q == R && m_axi.rvalid;
  assign rd_data_o     = m_axi.rdata;
  assign rd_last_o     = m_axi.rlast;
`ifdef AXIM_RESP_CHECK_EN
  logic [1:0] rmax_q, rmax_d, status_q, status_d;
  logic unused_ok;
  assign unused_ok = ^{m_axi.bid, m_axi.rid};
  // A read ending on rlast before len+1 beats is reported as SLVERR.
  always_comb begin
    rmax_d = (state_q != R) ? 2'b00 : (r_hs && m_axi.rresp > rmax_q) ? m_axi.rresp : rmax_q;
    status_d = (state_q == B) ? m_axi.bresp : (cnt_q != len_q) ? 2'b10 : rmax_d;
  end
  always_ff @(posedge clk) begin
    rmax_q   <= rst ? 2'b00 : rmax_d;
    status_q <= rst ? 2'b00 : done_d ? status_d : status_q;
  end
  assign done_status_o = status_q;
`else
  logic unused_ok;
  assign unused_ok = ^{m_axi.bid, m_axi.rid, m_axi.bresp, m_axi.rresp};
  assign done_status_o = 2'b00;
`endif
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed bursts against a small AXI4 slave memory model
module tb_axi_burst_master;
`ifdef AXIM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0, done_valid, wr_valid = 0, wr_ready;
  logic rd_last, rd_valid, rd_ready = 0;
  logic [15:0] cmd_addr = 0;
  logic [7:0] cmd_len = 0;
  logic [1:0] done_status;
  logic [31:0] wr_data = 0, rd_data;
  logic [3:0] wr_strb = 4'hF;
  int total = 0, bad = 0;
  axi_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) bus ();
  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .done_valid_o(done_valid), .done_status_o(done_status),
    .wr_data_i(wr_data), .wr_strb_i(wr_strb), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_last_o(rd_last), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .m_axi(bus)
  );
  // Slave: ready one cycle after valid on AW/AR, always-ready W, B after wlast, R streamed from mem.
  logic [31:0] mem [0:1023];
  logic [31:0] exp_mem [0:1023];
  logic s_awready = 0, s_arready = 0, s_bvalid = 0, r_act = 0;
  logic [1:0] s_bresp = 0, s_rresp = 0;
  logic [9:0] w_ptr = 0, r_ptr = 0;
  logic [7:0] r_beat = 0, r_len = 0;
  assign bus.awready = s_awready;
  assign bus.wready  = 1'b1;
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.bid     = '0;
  assign bus.arready = s_arready;
  assign bus.rvalid  = r_act;
  assign bus.rdata   = mem[r_ptr];
  assign bus.rresp   = s_rresp;
  assign bus.rlast   = r_beat == r_len;
  assign bus.rid     = '0;
  always @(posedge clk) begin
    if (rst) begin
      s_awready <= 0; s_arready <= 0; s_bvalid <= 0; r_act <= 0;
    end else begin
      s_awready <= bus.awvalid && !s_awready;
      s_arready <= bus.arvalid && !s_arready;
      if (bus.awvalid && s_awready) w_ptr <= bus.awaddr[11:2];
      if (s_bvalid && bus.bready) s_bvalid <= 0;
      if (bus.wvalid) begin
        mem[w_ptr] <= bus.wdata;
        w_ptr <= w_ptr + 10'd1;
        if (bus.wlast) s_bvalid <= 1;
      end
      if (bus.arvalid && s_arready) begin
        r_act <= 1; r_ptr <= bus.araddr[11:2]; r_beat <= 0; r_len <= bus.arlen;
      end else if (r_act && bus.rready) begin
        r_ptr <= r_ptr + 10'd1; r_beat <= r_beat + 8'd1;
        if (r_beat == r_len) r_act <= 0;
      end
    end
  end
  typedef struct {
    bit wr; logic [15:0] addr; logic [7:0] len; logic [31:0] seed; bit gaps; logic [1:0] bresp; logic [1:0] rresp;
  } vec_t;
  vec_t vecs [8];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  // Entered at a negedge just after the command was accepted; returns at the done cycle.
  task automatic run_body(input vec_t v);
    int beat = 0, rbeat = 0;
    bit fin = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      wr_valid = v.wr && beat <= int'(v.len) && !(v.gaps && cyc % 3 == 1);
      wr_data = v.seed + 32'(beat);
      rd_ready = !v.wr && (!v.gaps || cyc % 2 == 0);
      #1;
      if (cyc == 0 && v.wr) begin
        chk("awvalid", 32'(bus.awvalid), 1); chk("awaddr", 32'(bus.awaddr), 32'(v.addr));
        chk("awlen", 32'(bus.awlen), 32'(v.len)); chk("awsize", 32'(bus.awsize), 2);
        chk("awburst", 32'(bus.awburst), 1); chk("awcache", 32'(bus.awcache), 3);
        chk("awid", 32'(bus.awid), 0); chk("aw_lock_prot", 32'({bus.awlock, bus.awprot}), 0);
      end
      if (cyc == 0 && !v.wr) begin
        chk("arvalid", 32'(bus.arvalid), 1); chk("araddr", 32'(bus.araddr), 32'(v.addr));
        chk("arlen", 32'(bus.arlen), 32'(v.len)); chk("arsize", 32'(bus.arsize), 2);
        chk("arburst", 32'(bus.arburst), 1); chk("arcache", 32'(bus.arcache), 3);
      end
      if (wr_valid && wr_ready) begin
        chk("wdata", bus.wdata, v.seed + 32'(beat));
        chk("wstrb", 32'(bus.wstrb), 32'hF);
        chk("wlast", 32'(bus.wlast), 32'(beat == int'(v.len)));
        beat++;
      end
      if (rd_valid && rd_ready) begin
        chk("rd_data", rd_data, exp_mem[10'(int'(v.addr[11:2]) + rbeat)]);
        chk("rd_last", 32'(rd_last), 32'(rbeat == int'(v.len)));
        rbeat++;
      end
      if (done_valid) begin
        fin = 1;
        chk("cmd_ready_done", 32'(cmd_ready), 1);
        chk("done_status", 32'(done_status), CHK ? 32'(v.wr ? v.bresp : v.rresp) : 0);
        chk("beats", 32'(v.wr ? beat : rbeat), 32'(v.len) + 1);
      end else chk("cmd_ready_busy", 32'(cmd_ready), 0);
      if (!fin) begin @(posedge clk); @(negedge clk); end
    end
    if (!fin) chk("done_timeout", 0, 1);
  endtask
  task automatic preload(input vec_t v);
    s_bresp = v.bresp;
    s_rresp = v.rresp;
    if (v.wr) for (int i = 0; i <= int'(v.len); i++) exp_mem[10'(int'(v.addr[11:2]) + i)] = v.seed + 32'(i);
  endtask
  task automatic run(input vec_t v);
    preload(v);
    @(negedge clk);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    #1 chk("cmd_ready_idle", 32'(cmd_ready), 1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 0;
    run_body(v);
    wr_valid = 0; rd_ready = 0;
    @(posedge clk); @(negedge clk);
    #1 chk("done_pulse_1cyc", 32'(done_valid), 0);
  endtask
  initial begin
    vec_t a, b;
    int n;
    vecs[0] = '{1, 16'h0010, 8'd0, 32'hDEADBEEF, 0, 2'b00, 2'b00};
    vecs[1] = '{1, 16'h0100, 8'd3, 32'h00000001, 0, 2'b00, 2'b00};
    vecs[2] = '{0, 16'h0100, 8'd3, 32'h0,        0, 2'b00, 2'b00};
    vecs[3] = '{1, 16'h0200, 8'd7, 32'hA0000000, 1, 2'b00, 2'b00};
    vecs[4] = '{0, 16'h0200, 8'd7, 32'h0,        1, 2'b00, 2'b00};
    vecs[5] = '{0, 16'h0010, 8'd0, 32'h0,        0, 2'b00, 2'b00};
    vecs[6] = '{1, 16'h0020, 8'd0, 32'h12345678, 0, 2'b10, 2'b00};
    vecs[7] = '{0, 16'h0100, 8'd1, 32'h0,        0, 2'b00, 2'b01};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1); chk("rst_done_valid", 32'(done_valid), 0);
    chk("rst_done_status", 32'(done_status), 0); chk("rst_awvalid", 32'(bus.awvalid), 0);
    chk("rst_arvalid", 32'(bus.arvalid), 0); chk("rst_bready", 32'(bus.bready), 0);
    chk("rst_rready", 32'(bus.rready), 0);
    rst = 0;
    foreach (vecs[i]) run(vecs[i]);
    // Back-to-back: cmd_valid held through a write; the read is taken in the done cycle.
    a = '{1, 16'h0300, 8'd1, 32'h55550000, 0, 2'b00, 2'b00};
    b = '{0, 16'h0300, 8'd1, 32'h0, 0, 2'b00, 2'b00};
    preload(a);
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = a.addr; cmd_len = a.len;
    @(posedge clk); @(negedge clk);
    cmd_write = 0;
    run_body(a);
    wr_valid = 0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 0;
    run_body(b);
    rd_ready = 0;
    @(posedge clk); @(negedge clk);
    // Reset after two of four write beats.
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0400; cmd_len = 8'd3;
    @(posedge clk); @(negedge clk);
    cmd_valid = 0;
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      wr_valid = 1; wr_data = 32'(c);
      #1 if (wr_ready) n++;
      @(posedge clk); @(negedge clk);
    end
    chk("pre_rst_beats", 32'(n), 2);
    rst = 1; wr_valid = 1; rd_ready = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_awvalid", 32'(bus.awvalid), 0); chk("mid_rst_wvalid", 32'(bus.wvalid), 0);
    chk("mid_rst_arvalid", 32'(bus.arvalid), 0); chk("mid_rst_bready", 32'(bus.bready), 0);
    chk("mid_rst_rready", 32'(bus.rready), 0); chk("mid_rst_wr_ready", 32'(wr_ready), 0);
    chk("mid_rst_done", 32'(done_valid), 0);
    @(negedge clk);
    rst = 0; wr_valid = 0; rd_ready = 0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("post_rst_status", 32'(done_status), 0);
    run(vecs[2]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end
endmodule
